uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Consumes the byte stream that the memory controller emits on a store to the UART address (`uart` byte plus `uart_we` strobe).
- Buffers bytes in a small FIFO and serialises each one onto `txd` as 8N1 at a fixed baud rate.
- Sits between the memory controller and the board TX pin. The CPU can burst stores faster than line rate without stalling.
- Bytes beyond FIFO capacity are dropped and recorded in a sticky flag.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide), must be >= 2.
- FIFO_DEPTH, 16, byte entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- uart_we  input  1  push strobe from the memory controller; one byte per high cycle.
- uart_data  input  8  byte to transmit, sampled when uart_we=1.
- txd  output  1  serial line, idle high.
- tx_busy  output  1  1 while a frame is on the line or the FIFO is non-empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (async assert, deassert synchronised by the caller):
  - txd=1, tx_busy=0, fifo_full=0, overflow=0.
  - FIFO empty, FSM in IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately; txd returns high with no glitch low.
- FIFO:
  - Push when uart_we=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - Push when full with no same-cycle pop is dropped and sets overflow=1. overflow clears only on rst.
  - Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH, so its width is clog2(FIFO_DEPTH)+1.
  - Simultaneous push+pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO non-empty: pop head into shift register, clear baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: txd=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right after each bit. After bit 7 go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
    - At the end, if FIFO non-empty, pop and go directly to START: back-to-back frames, no idle gap.
    - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit boundaries occur on the wrap.
- txd is a registered output.
- Latency:
  - Push sampled at edge E0; FIFO non-empty after E0.
  - At E1 the FSM pops and txd goes low.
  - First data bit starts at E1+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx_busy = (state!=IDLE) or (count!=0). It is registered, or combinational from registers only.
- uart_data is sampled only when uart_we=1; at other times it is ignored.

Decomposition:
- define.vh (existing shared header) gains:
  - UART FSM state encodings (UART_IDLE, UART_START, UART_DATA, UART_STOP, 2 bits).
  - Default CLK_FREQ and BAUD_RATE.
  - UART_ADDR stays there.
- One sub-module, uart_fifo: synchronous FIFO with push/pop/full/empty/count, same clk/rst, width 8, depth parameter.
- Baud counter and FSM stay in uart_tx.

Test Plan (sim with CLK_FREQ=100, BAUD_RATE=10, so CLKS_PER_BIT=10; FIFO_DEPTH=4):
- Reset: assert rst asynchronously mid-cycle -> txd=1, tx_busy=0, overflow=0 immediately, before the next clk edge.
- Single byte: push 0x55 at E0 -> txd low from E1 for 10 cycles. Then 1,0,1,0,1,0,1,0 (10 cycles each), then high 10 cycles. tx_busy falls at E1+100.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles -> frames contiguous. Second start bit begins exactly at E1+100. Decoded bytes are 0xA3, 0x0F.
- Overflow: push 6 bytes 0x01..0x06 on consecutive cycles. 0x01 is popped at E1, so 4 more fit. Assert fifo_full after the 5th push. 0x06 dropped, overflow=1 and stays 1. Line shows 0x01..0x05.
- Push+pop when full: keep FIFO full, push on the cycle the STOP→START pop occurs -> byte accepted, count stays 4, overflow unchanged.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF -> txd=1 at once. After release, no residual frame. A new push of 0x00 transmits correctly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART state encodings, default line parameters and bus address
package uart_tx_pkg;
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD_RATE = 115_200;
  localparam logic [31:0] UART_ADDR = 32'h1000_0000;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: store-side push strobe from the memory controller plus line/status outputs
interface uart_tx_if;
  logic       uart_we;
  logic [7:0] uart_data;
  logic       txd;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;
  modport master (output uart_we, uart_data, input txd, tx_busy, fifo_full, overflow);
  modport slave (input uart_we, uart_data, output txd, tx_busy, fifo_full, overflow);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: byte FIFO; caller guarantees no push when full without a same-cycle pop, no pop when empty
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i) rp_q <= rp_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign rdata_o = mem_q[rp_q];
  assign count_o = count_q;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffers pushed bytes and serialises them as 8N1 on txd, back-to-back when queued
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int FIFO_DEPTH = 16
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  uart_state_e              state_q, state_d;
  logic [CW-1:0]            baud_q, baud_d;
  logic [2:0]               bit_q, bit_d;
  logic [7:0]               shift_q, shift_d, head;
  logic                     txd_q, txd_d, ovf_q;
  logic                     pop, push, full, empty, wrap;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign wrap = baud_q == LAST;
  assign push = bus.uart_we && (!full || pop);
  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .wdata_i(bus.uart_data),
    .rdata_o(head), .count_o(count), .full_o(full), .empty_o(empty)
  );
  // txd_d is the line level for the state being entered, so txd stays a plain register
  always_comb begin
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      UART_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = UART_START;
          txd_d   = 1'b0;
        end
      end
      UART_START: if (wrap) begin
        state_d = UART_DATA;
        bit_d   = '0;
        txd_d   = shift_q[0];
      end
      UART_DATA: if (wrap) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? UART_STOP : UART_DATA;
        txd_d   = bit_q == 3'd7 ? 1'b1 : shift_q[1];
      end
      UART_STOP: if (wrap) begin
        pop     = !empty;
        shift_d = empty ? shift_q : head;
        state_d = empty ? UART_IDLE : UART_START;
        txd_d   = empty;
      end
      default: state_d = UART_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (bus.uart_we && !push) ovf_q <= 1'b1;
    end
  assign bus.txd       = txd_q;
  assign bus.tx_busy   = state_q != UART_IDLE || count != '0;
  assign bus.fifo_full = full;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed pushes checked every cycle against a frame-schedule model plus a line decoder
module tb_uart_tx;
  localparam int CPB = 10, DEPTH = 4, FRAME = 10 * CPB;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  uart_tx_if bus();
  uart_tx #(.CLK_FREQ(100), .BAUD_RATE(10), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // model: queue of waiting bytes plus position t inside the current 10*CPB frame
  logic [7:0] mq[$], done[$], rx[$];
  int starts[$];
  logic [7:0] cur;
  bit act, movf;
  int t;
  always @(posedge clk or posedge rst) begin
    bit mpop, acc;
    if (rst) begin
      mq.delete();
      act = 0; t = 0; movf = 0;
    end else begin
      mpop = mq.size() > 0 && (!act || t == FRAME - 1);
      acc = bus.uart_we && (mq.size() < DEPTH || mpop);
      if (bus.uart_we && !acc) movf = 1;
      if (act && t == FRAME - 1) done.push_back(cur);
      if (mpop) begin cur = mq.pop_front(); t = 0; act = 1; end
      else if (act && t == FRAME - 1) act = 0;
      else if (act) t++;
      if (acc) mq.push_back(bus.uart_data);
    end
  end
  function automatic logic exp_txd();
    int b;
    if (!act) return 1'b1;
    b = t / CPB;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : cur[b-1];
  endfunction
  always @(negedge clk) begin
    check("txd", bus.txd, exp_txd());
    check("tx_busy", bus.tx_busy, act || mq.size() != 0);
    check("fifo_full", bus.fifo_full, mq.size() == DEPTH);
    check("overflow", bus.overflow, movf);
  end
  task automatic wait_n(input int n, inout bit ab);
    repeat (n) begin @(negedge clk); ab |= rst; end
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst && bus.txd === 1'b0) begin
      bit ab;
      logic [7:0] b;
      int st;
      ab = 0; st = cyc;
      wait_n(CPB / 2, ab);
      for (int i = 0; i < 8; i++) begin wait_n(CPB, ab); b[i] = bus.txd; end
      wait_n(CPB, ab);
      if (!ab) begin
        check("stop_bit", bus.txd, 1);
        rx.push_back(b);
        starts.push_back(st);
      end
    end
  end
  task automatic push(input logic [7:0] d);
    bus.uart_we = 1; bus.uart_data = d;
    @(negedge clk);
    bus.uart_we = 0; bus.uart_data = $urandom;
  endtask
  task automatic until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (bus.tx_busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    check("drain", bus.tx_busy, 0);
    repeat (5) @(negedge clk);
  endtask
  initial begin
    int e0, e1, n0;
    bus.uart_we = 0; bus.uart_data = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    push(8'h55); e1 = cyc + 1;
    until_cyc(e1);       check("start_low", bus.txd, 0);
    until_cyc(e1 + 9);   check("start_end", bus.txd, 0);
    until_cyc(e1 + 10);  check("bit0", bus.txd, 1);
    until_cyc(e1 + 20);  check("bit1", bus.txd, 0);
    until_cyc(e1 + 99);  check("busy_stop", bus.tx_busy, 1);
    until_cyc(e1 + 100); check("busy_fall", bus.tx_busy, 0); check("idle_high", bus.txd, 1);
    repeat (5) @(negedge clk);
    check("rx_55_cnt", rx.size(), 1);
    check("rx_55", rx[0], 8'h55);
    n0 = rx.size();
    push(8'hA3); e1 = cyc + 1; push(8'h0F);
    wait_idle(400);
    check("b2b_cnt", rx.size(), n0 + 2);
    check("b2b_first_start", starts[n0], e1);
    check("b2b_gap", starts[n0+1] - starts[n0], FRAME);
    check("b2b_a3", rx[n0], 8'hA3);
    check("b2b_0f", rx[n0+1], 8'h0F);
    n0 = rx.size();
    for (int i = 1; i <= 6; i++) begin
      push(8'(i));
      if (i == 5) begin check("full_5th", bus.fifo_full, 1); check("no_ovf_5th", bus.overflow, 0); end
      if (i == 6) check("ovf_6th", bus.overflow, 1);
    end
    wait_idle(800);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_cnt", rx.size(), n0 + 5);
    for (int i = 0; i < 5; i++) check("ovf_byte", rx[n0+i], 32'(i + 1));
    @(negedge clk); #2 rst = 1; #1;
    check("rst_txd", bus.txd, 1); check("rst_busy", bus.tx_busy, 0);
    check("rst_ovf", bus.overflow, 0); check("rst_full", bus.fifo_full, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    n0 = rx.size();
    push(8'h11); e0 = cyc;
    push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("pp_full", bus.fifo_full, 1);
    until_cyc(e0 + 100);
    push(8'h66);
    check("pp_still_full", bus.fifo_full, 1);
    check("pp_no_ovf", bus.overflow, 0);
    wait_idle(800);
    check("pp_cnt", rx.size(), n0 + 6);
    for (int i = 0; i < 6; i++) check("pp_byte", rx[n0+i], 32'(8'h11 * (i + 1)));
    n0 = rx.size();
    push(8'hFF); e1 = cyc + 1;
    until_cyc(e1 + 45);
    check("ff_bit3_high", bus.txd, 1);
    #2 rst = 1; #1;
    check("abort_txd", bus.txd, 1); check("abort_busy", bus.tx_busy, 0);
    @(negedge clk); rst = 0;
    repeat (150) @(negedge clk);
    check("no_residual", rx.size(), n0);
    check("post_abort_busy", bus.tx_busy, 0);
    push(8'h00);
    wait_idle(400);
    check("zero_cnt", rx.size(), n0 + 1);
    check("zero_byte", rx[n0], 8'h00);
    repeat (3000) begin
      bus.uart_we = $urandom_range(0, 29) == 0;
      bus.uart_data = 8'($urandom);
      @(negedge clk);
    end
    bus.uart_we = 0;
    wait_idle(2000);
    check("rx_total", rx.size(), done.size());
    for (int i = 0; i < rx.size() && i < done.size(); i++) check("rx_vs_model", rx[i], done[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
